// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
// Defaults match the keypad input stage and the display driver.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_BIN_W   = 14;
  localparam int BCD_DIGITS  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_e;

  // True when DIGITS decimal digits can hold every BIN_W-bit value.
  function automatic bit bcd_fits(
    input int digits,
    input int bin_w
  );
    longint unsigned p;
    longint unsigned lim;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    lim = 64'd1 << bin_w;
    return p > lim;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
// Results stay within 4 bits for any legal BCD input.
module bcd_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  always_comb begin
    dig_o = dig_i;
    if (dig_i >= 4'd5) begin
      dig_o = dig_i + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_display_conv.sv
// Iterative shift-and-add-3 binary-to-BCD converter, valid/ready both sides.
// Optional leading-zero mask output enabled by BCD_BLANK_EN.
module bcd_display_conv
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BCD_BIN_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             bin_in,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]            blank_mask,
`endif
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  if (!bcd_fits(DIGITS, BIN_W)) begin : g_bad_cfg
    $error("bcd_display_conv: DIGITS too small for BIN_W");
  end

  bcd_state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    scr_q, scr_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    scr_adj;
  logic [BW-1:0]    scr_n;
  logic [BW+BIN_W-1:0] cat;
  logic             upd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dig_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    cat   = {scr_adj, sh_q} << 1;
    scr_n = cat[BW+BIN_W-1:BIN_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    upd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_n;
        sh_d  = cat[BIN_W-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_n;
          upd     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything; the delivered result is kept.
    if (clear) begin
      state_d = IDLE;
      scr_d   = '0;
      bcd_d   = bcd_q;
      upd     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              zrun;

  // Bit i is set while digit i and everything above it are zero.
  always_comb begin
    mask_d = mask_q;
    zrun   = 1'b1;
    if (upd) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        zrun = zrun &
          (scr_n[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
        mask_d[i] = zrun;
      end
      mask_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= ~DIGITS'(1);
    end else begin
      mask_q <= mask_d;
    end
  end

  assign blank_mask = mask_q;
`endif

endmodule

// File: tb/tb_bcd_display_conv.sv
// Directed self-checking bench for bcd_display_conv.
// Blank-mask checks are included when BCD_BLANK_EN is defined.
module tb_bcd_display_conv;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd_out;
`ifdef BCD_BLANK_EN
  logic [4:0]  blank_mask;
`endif

  int ncmp = 0;
  int nerr = 0;
  int n;
  bit seen;

  bcd_display_conv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_in     (bin_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef BCD_BLANK_EN
    .blank_mask (blank_mask),
`endif
    .bcd_out    (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mask(
    input string      tag,
    input logic [4:0] exp
  );
`ifdef BCD_BLANK_EN
    chk(tag, 32'(blank_mask), 32'(exp));
`endif
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic start(input logic [13:0] v);
    bin_in   = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin_in    = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h00000);
    chk_mask("rst_mask", 5'b11110);

    start(14'd420);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    wait_done(n);
    chk("lat_420", n, 14);
    chk("bcd_420", 32'(bcd_out), 32'h00420);
    chk_mask("mask_420", 5'b11000);
    handshake();
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);

    start(14'd16383);
    wait_done(n);
    chk("lat_16383", n, 14);
    chk("bcd_16383", 32'(bcd_out), 32'h16383);
    chk_mask("mask_16383", 5'b00000);
    handshake();

    start(14'd0);
    wait_done(n);
    chk("bcd_0", 32'(bcd_out), 32'h00000);
    chk_mask("mask_0", 5'b11110);
    handshake();

    start(14'd9999);
    wait_done(n);
    chk("bcd_9999", 32'(bcd_out), 32'h09999);
    chk_mask("mask_9999", 5'b10000);
    handshake();

    // Backpressure with a pending request.
    start(14'd77);
    wait_done(n);
    chk("bcd_77", 32'(bcd_out), 32'h00077);
    bin_in   = 14'd55;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_bcd", 32'(bcd_out), 32'h00077);
    end
    handshake();
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept", 32'(in_ready), 32'd0);
    wait_done(n);
    chk("lat_55", n, 14);
    chk("bcd_55", 32'(bcd_out), 32'h00055);
    handshake();

    // Clear in IDLE blocks a simultaneous accept.
    clear    = 1'b1;
    in_valid = 1'b1;
    bin_in   = 14'd88;
    cyc(1);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_noacc", 32'(in_ready), 32'd1);

    // Abort mid-conversion.
    start(14'd123);
    wait_done(n);
    chk("bcd_123", 32'(bcd_out), 32'h00123);
    handshake();
    start(14'd4567);
    cyc(7);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_idle", 32'(in_ready), 32'd1);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_bcd", 32'(bcd_out), 32'h00123);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (out_valid) seen = 1'b1;
    end
    chk("clr_never_valid", 32'(seen), 32'd0);
    chk("clr_bcd_hold", 32'(bcd_out), 32'h00123);

    // Asynchronous reset mid-conversion.
    start(14'd4567);
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_bcd", 32'(bcd_out), 32'h00000);
    chk_mask("arst_mask", 5'b11110);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    start(14'd5);
    wait_done(n);
    chk("lat_5", n, 14);
    chk("bcd_5", 32'(bcd_out), 32'h00005);
    chk_mask("mask_5", 5'b11110);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
